// File: rtl/writeback_store_if.sv
// Data-cache core port used by the writeback stage for stores:
// request (req/ack) plus completion (resp/respack) handshake.
interface writeback_store_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 13
);
  logic              reqcyc;
  logic [ADDR_W-1:0] req;
  logic [DATA_W-1:0] reqdata;
  logic [TAG_W-1:0]  reqtag;
  logic              reqack;
  logic              respcyc;
  logic              respack;

  modport master (
    output reqcyc, req, reqdata, reqtag, respack,
    input  reqack, respcyc
  );

  modport slave (
    input  reqcyc, req, reqdata, reqtag, respack,
    output reqack, respcyc
  );
endinterface

// File: rtl/writeback_store.sv
// Final pipeline stage: issues memory-destination stores through the cache
// port, then commits GPR / special-register results and retires the next-RIP.
module writeback_store #(
  parameter int         ADDR_W      = 64,
  parameter int         DATA_W      = 64,
  parameter int         TAG_W       = 13,
  parameter logic       WRITE_CODE  = 1'b1,
  parameter logic [3:0] MEMORY_CODE = 4'h1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              validIn,
  input  logic              isMemorySuccessfulIn,
  input  logic [63:0]       currentRipIn,
  input  logic [31:0]       instructionLengthIn,
  input  logic [7:0]        opcodeIn,
  input  logic [3:0]        destRegIn,
  input  logic              destRegValidIn,
  input  logic [DATA_W-1:0] destRegValueIn,
  input  logic [3:0]        destRegSpecialIn,
  input  logic              destRegSpecialValidIn,
  input  logic              isMemoryAccessDestIn,
  input  logic [ADDR_W-1:0] memoryAddressDestIn,
  output logic              wbStallOut,
  writeback_store_if.master dc,
  output logic              regWrEn,
  output logic [3:0]        regWrIdx,
  output logic [DATA_W-1:0] regWrData,
  output logic              specWrEn,
  output logic [3:0]        specWrIdx,
  output logic [DATA_W-1:0] specWrData,
  output logic              retireValidOut,
  output logic [63:0]       retiredRipOut
);

  typedef enum logic [1:0] {IDLE, STORE_REQ, STORE_WAIT, COMMIT} state_t;

  state_t state_q, state_d;

  // Instruction fields captured at accept, consumed when a store commits.
  logic [63:0]       rip_q;
  logic [31:0]       len_q;
  logic [3:0]        dest_idx_q, spec_idx_q;
  logic              dest_valid_q, spec_valid_q;
  logic [DATA_W-1:0] value_q;

  logic              reqcyc_q, reqcyc_d;
  logic [ADDR_W-1:0] req_q, req_d;
  logic [DATA_W-1:0] reqdata_q, reqdata_d;
  logic [TAG_W-1:0]  reqtag_q, reqtag_d;
  logic              respack_q, respack_d;
  logic              reg_wr_en_q, reg_wr_en_d;
  logic [3:0]        reg_wr_idx_q, reg_wr_idx_d;
  logic [DATA_W-1:0] reg_wr_data_q, reg_wr_data_d;
  logic              spec_wr_en_q, spec_wr_en_d;
  logic [3:0]        spec_wr_idx_q, spec_wr_idx_d;
  logic [DATA_W-1:0] spec_wr_data_q, spec_wr_data_d;
  logic              retire_q, retire_d;
  logic [63:0]       retired_rip_q, retired_rip_d;

  logic ready, accept;
  assign ready      = (state_q == IDLE) || (state_q == COMMIT);
  assign accept     = validIn && isMemorySuccessfulIn && ready;
  assign wbStallOut = !ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COMMIT: begin
        if (accept) state_d = isMemoryAccessDestIn ? STORE_REQ : COMMIT;
        else        state_d = IDLE;
      end
      STORE_REQ: begin
        if (dc.reqack) state_d = dc.respcyc ? COMMIT : STORE_WAIT;
      end
      STORE_WAIT: begin
        if (dc.respcyc) state_d = COMMIT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Output next-values; a non-store commits straight from the inputs,
  // a store commits from the fields latched when it was accepted.
  always_comb begin
    logic [63:0]       src_rip;
    logic [31:0]       src_len;
    logic [3:0]        src_dest_idx, src_spec_idx;
    logic              src_dest_valid, src_spec_valid;
    logic [DATA_W-1:0] src_value;

    src_rip        = accept ? currentRipIn          : rip_q;
    src_len        = accept ? instructionLengthIn   : len_q;
    src_dest_idx   = accept ? destRegIn             : dest_idx_q;
    src_spec_idx   = accept ? destRegSpecialIn      : spec_idx_q;
    src_dest_valid = accept ? destRegValidIn        : dest_valid_q;
    src_spec_valid = accept ? destRegSpecialValidIn : spec_valid_q;
    src_value      = accept ? destRegValueIn        : value_q;

    reqcyc_d       = reqcyc_q;
    req_d          = req_q;
    reqdata_d      = reqdata_q;
    reqtag_d       = reqtag_q;
    respack_d      = 1'b0;
    reg_wr_en_d    = 1'b0;
    reg_wr_idx_d   = reg_wr_idx_q;
    reg_wr_data_d  = reg_wr_data_q;
    spec_wr_en_d   = 1'b0;
    spec_wr_idx_d  = spec_wr_idx_q;
    spec_wr_data_d = spec_wr_data_q;
    retire_d       = 1'b0;
    retired_rip_d  = retired_rip_q;

    if (accept && isMemoryAccessDestIn) begin
      reqcyc_d  = 1'b1;
      req_d     = memoryAddressDestIn;
      reqdata_d = destRegValueIn;
      reqtag_d  = {WRITE_CODE, MEMORY_CODE, opcodeIn};
    end else if (state_q == STORE_REQ && dc.reqack) begin
      reqcyc_d = 1'b0;
    end

    if ((state_q == STORE_REQ && dc.reqack && dc.respcyc) ||
        (state_q == STORE_WAIT && dc.respcyc)) begin
      respack_d = 1'b1;
    end

    if (state_d == COMMIT) begin
      reg_wr_en_d    = src_dest_valid;
      reg_wr_idx_d   = src_dest_idx;
      reg_wr_data_d  = src_value;
      spec_wr_en_d   = src_spec_valid;
      spec_wr_idx_d  = src_spec_idx;
      spec_wr_data_d = src_value;
      retire_d       = 1'b1;
      retired_rip_d  = src_rip + {32'd0, src_len};
    end
  end

  // Registered outputs and latched instruction fields
  always_ff @(posedge clk) begin
    if (!reset) begin
      reqcyc_q       <= 1'b0;
      req_q          <= '0;
      reqdata_q      <= '0;
      reqtag_q       <= '0;
      respack_q      <= 1'b0;
      reg_wr_en_q    <= 1'b0;
      reg_wr_idx_q   <= '0;
      reg_wr_data_q  <= '0;
      spec_wr_en_q   <= 1'b0;
      spec_wr_idx_q  <= '0;
      spec_wr_data_q <= '0;
      retire_q       <= 1'b0;
      retired_rip_q  <= '0;
      rip_q          <= '0;
      len_q          <= '0;
      dest_idx_q     <= '0;
      spec_idx_q     <= '0;
      dest_valid_q   <= 1'b0;
      spec_valid_q   <= 1'b0;
      value_q        <= '0;
    end else begin
      reqcyc_q       <= reqcyc_d;
      req_q          <= req_d;
      reqdata_q      <= reqdata_d;
      reqtag_q       <= reqtag_d;
      respack_q      <= respack_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_idx_q   <= reg_wr_idx_d;
      reg_wr_data_q  <= reg_wr_data_d;
      spec_wr_en_q   <= spec_wr_en_d;
      spec_wr_idx_q  <= spec_wr_idx_d;
      spec_wr_data_q <= spec_wr_data_d;
      retire_q       <= retire_d;
      retired_rip_q  <= retired_rip_d;
      if (accept) begin
        rip_q        <= currentRipIn;
        len_q        <= instructionLengthIn;
        dest_idx_q   <= destRegIn;
        spec_idx_q   <= destRegSpecialIn;
        dest_valid_q <= destRegValidIn;
        spec_valid_q <= destRegSpecialValidIn;
        value_q      <= destRegValueIn;
      end
    end
  end

  assign dc.reqcyc      = reqcyc_q;
  assign dc.req         = req_q;
  assign dc.reqdata     = reqdata_q;
  assign dc.reqtag      = reqtag_q;
  assign dc.respack     = respack_q;
  assign regWrEn        = reg_wr_en_q;
  assign regWrIdx       = reg_wr_idx_q;
  assign regWrData      = reg_wr_data_q;
  assign specWrEn       = spec_wr_en_q;
  assign specWrIdx      = spec_wr_idx_q;
  assign specWrData     = spec_wr_data_q;
  assign retireValidOut = retire_q;
  assign retiredRipOut  = retired_rip_q;

endmodule

// File: tb/tb_writeback_store.sv
// Scoreboard bench for writeback_store: stimulus queues expectations,
// a negedge monitor pops and compares them.
module tb_writeback_store;

  logic        clk = 1'b0;
  logic        reset;
  logic        validIn, isMemorySuccessfulIn;
  logic [63:0] currentRipIn;
  logic [31:0] instructionLengthIn;
  logic [7:0]  opcodeIn;
  logic [3:0]  destRegIn, destRegSpecialIn;
  logic        destRegValidIn, destRegSpecialValidIn, isMemoryAccessDestIn;
  logic [63:0] destRegValueIn, memoryAddressDestIn;
  logic        wbStallOut;
  logic        regWrEn, specWrEn, retireValidOut;
  logic [3:0]  regWrIdx, specWrIdx;
  logic [63:0] regWrData, specWrData, retiredRipOut;

  writeback_store_if #(.ADDR_W(64), .DATA_W(64), .TAG_W(13)) dc_if ();

  writeback_store dut (
    .clk                   (clk),
    .reset                 (reset),
    .validIn               (validIn),
    .isMemorySuccessfulIn  (isMemorySuccessfulIn),
    .currentRipIn          (currentRipIn),
    .instructionLengthIn   (instructionLengthIn),
    .opcodeIn              (opcodeIn),
    .destRegIn             (destRegIn),
    .destRegValidIn        (destRegValidIn),
    .destRegValueIn        (destRegValueIn),
    .destRegSpecialIn      (destRegSpecialIn),
    .destRegSpecialValidIn (destRegSpecialValidIn),
    .isMemoryAccessDestIn  (isMemoryAccessDestIn),
    .memoryAddressDestIn   (memoryAddressDestIn),
    .wbStallOut            (wbStallOut),
    .dc                    (dc_if.master),
    .regWrEn               (regWrEn),
    .regWrIdx              (regWrIdx),
    .regWrData             (regWrData),
    .specWrEn              (specWrEn),
    .specWrIdx             (specWrIdx),
    .specWrData            (specWrData),
    .retireValidOut        (retireValidOut),
    .retiredRipOut         (retiredRipOut)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        reg_en;
    logic [3:0]  reg_idx;
    logic        spec_en;
    logic [3:0]  spec_idx;
    logic [63:0] data;
    logic [63:0] rip;
  } retire_t;

  typedef struct {
    logic [63:0] addr;
    logic [63:0] data;
    logic [12:0] tag;
  } store_t;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } chk_t;

  localparam int S_STALL = 0, S_REQCYC = 1, S_RESPACK = 2, S_REGWR = 3,
                 S_RETIRE = 4, S_REQTAG = 5, S_RQ_LEFT = 6, S_SQ_LEFT = 7;

  retire_t retire_q[$];
  store_t  store_q[$];
  chk_t    chk_q[$];
  int      total = 0;
  int      bad = 0;
  logic    reqcyc_prev = 1'b0;

  function automatic logic [63:0] sample(input int sel);
    case (sel)
      S_STALL:   return {63'd0, wbStallOut};
      S_REQCYC:  return {63'd0, dc_if.reqcyc};
      S_RESPACK: return {63'd0, dc_if.respack};
      S_REGWR:   return {63'd0, regWrEn};
      S_RETIRE:  return {63'd0, retireValidOut};
      S_REQTAG:  return {51'd0, dc_if.reqtag};
      S_RQ_LEFT: return 64'(retire_q.size());
      default:   return 64'(store_q.size());
    endcase
  endfunction

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: the only process that compares and counts
  always @(negedge clk) begin
    while (chk_q.size() > 0) begin
      chk_t c;
      c = chk_q.pop_front();
      cmp(c.name, sample(c.sel), c.exp);
    end
    if (reset && dc_if.reqcyc && !reqcyc_prev) begin
      if (store_q.size() == 0) begin
        cmp("unexpected_store", 64'd1, 64'd0);
      end else begin
        store_t s;
        s = store_q.pop_front();
        cmp("store_addr", dc_if.req, s.addr);
        cmp("store_data", dc_if.reqdata, s.data);
        cmp("store_tag", {51'd0, dc_if.reqtag}, {51'd0, s.tag});
        $display("store issued addr=0x%0h data=0x%0h tag=0x%0h", dc_if.req, dc_if.reqdata, dc_if.reqtag);
      end
    end
    reqcyc_prev = dc_if.reqcyc;
    if (reset && retireValidOut) begin
      if (retire_q.size() == 0) begin
        cmp("unexpected_retire", 64'd1, 64'd0);
      end else begin
        retire_t r;
        r = retire_q.pop_front();
        cmp("regWrEn", {63'd0, regWrEn}, {63'd0, r.reg_en});
        cmp("regWrIdx", {60'd0, regWrIdx}, {60'd0, r.reg_idx});
        cmp("regWrData", regWrData, r.data);
        cmp("specWrEn", {63'd0, specWrEn}, {63'd0, r.spec_en});
        cmp("specWrIdx", {60'd0, specWrIdx}, {60'd0, r.spec_idx});
        cmp("specWrData", specWrData, r.data);
        cmp("retiredRip", retiredRipOut, r.rip);
        $display("retire rip=0x%0h regWrEn=%0b data=0x%0h", retiredRipOut, regWrEn, regWrData);
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_now(input string name, input int sel, input logic [63:0] exp);
    chk_t c;
    c.name = name;
    c.sel  = sel;
    c.exp  = exp;
    chk_q.push_back(c);
  endtask

  task automatic drive(input logic store, input logic [63:0] rip, input logic [31:0] len,
                       input logic [7:0] opc, input logic [3:0] dst, input logic dst_v,
                       input logic [63:0] val, input logic [3:0] spc, input logic spc_v,
                       input logic [63:0] addr);
    validIn               = 1'b1;
    isMemorySuccessfulIn  = 1'b1;
    isMemoryAccessDestIn  = store;
    currentRipIn          = rip;
    instructionLengthIn   = len;
    opcodeIn              = opc;
    destRegIn             = dst;
    destRegValidIn        = dst_v;
    destRegValueIn        = val;
    destRegSpecialIn      = spc;
    destRegSpecialValidIn = spc_v;
    memoryAddressDestIn   = addr;
  endtask

  task automatic push_retire(input logic re, input logic [3:0] ri, input logic se,
                             input logic [3:0] si, input logic [63:0] d, input logic [63:0] rip);
    retire_t r;
    r.reg_en = re; r.reg_idx = ri; r.spec_en = se; r.spec_idx = si; r.data = d; r.rip = rip;
    retire_q.push_back(r);
  endtask

  task automatic push_store(input logic [63:0] a, input logic [63:0] d, input logic [12:0] t);
    store_t s;
    s.addr = a; s.data = d; s.tag = t;
    store_q.push_back(s);
  endtask

  // Back-to-back table: dest, value, rip, len, expected retired RIP
  logic [3:0]  bb_dst [4] = '{4'd1, 4'd2, 4'd7, 4'd9};
  logic [63:0] bb_val [4] = '{64'h11, 64'h22, 64'hABCD, 64'h99};
  logic [63:0] bb_rip [4] = '{64'h100, 64'h200, 64'hFFFF_FFFF_FFFF_FFFE, 64'h8000_0000_0000_0000};
  logic [31:0] bb_len [4] = '{32'd1, 32'd15, 32'd4, 32'hFFFF_FFFF};
  logic [63:0] bb_exp [4] = '{64'h101, 64'h20F, 64'h2, 64'h8000_0000_FFFF_FFFF};

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    validIn = 1'b0; isMemorySuccessfulIn = 1'b0; isMemoryAccessDestIn = 1'b0;
    currentRipIn = '0; instructionLengthIn = '0; opcodeIn = '0;
    destRegIn = '0; destRegValidIn = 1'b0; destRegValueIn = '0;
    destRegSpecialIn = '0; destRegSpecialValidIn = 1'b0; memoryAddressDestIn = '0;
    dc_if.reqack = 1'b0; dc_if.respcyc = 1'b0;
    cyc(); cyc();
    expect_now("rst_reqcyc", S_REQCYC, 0);
    expect_now("rst_respack", S_RESPACK, 0);
    expect_now("rst_regWrEn", S_REGWR, 0);
    expect_now("rst_retire", S_RETIRE, 0);
    expect_now("rst_stall", S_STALL, 0);
    cyc();
    reset = 1'b1;

    // Single non-store
    cyc();
    drive(1'b0, 64'h1000, 32'd3, 8'h01, 4'd3, 1'b1, 64'hDEAD, 4'd0, 1'b0, 64'h0);
    push_retire(1'b1, 4'd3, 1'b0, 4'd0, 64'hDEAD, 64'h1003);
    expect_now("ns_stall_accept", S_STALL, 0);
    cyc();
    validIn = 1'b0;
    expect_now("ns_regWrEn", S_REGWR, 1);
    expect_now("ns_retire", S_RETIRE, 1);
    expect_now("ns_stall_commit", S_STALL, 0);
    cyc();
    expect_now("ns_retire_drop", S_RETIRE, 0);

    // Store with delayed ack and delayed response
    cyc();
    drive(1'b1, 64'h1010, 32'd2, 8'h89, 4'd4, 1'b0, 64'h55, 4'd5, 1'b1, 64'h2000);
    push_store(64'h2000, 64'h55, 13'h1189);
    push_retire(1'b0, 4'd4, 1'b1, 4'd5, 64'h55, 64'h1012);
    cyc();
    validIn = 1'b0;
    expect_now("st_reqcyc_c1", S_REQCYC, 1);
    expect_now("st_reqtag", S_REQTAG, 64'h1189);
    expect_now("st_stall_c1", S_STALL, 1);
    expect_now("st_no_retire_c1", S_RETIRE, 0);
    cyc();
    expect_now("st_reqcyc_c2", S_REQCYC, 1);
    expect_now("st_stall_c2", S_STALL, 1);
    cyc();
    dc_if.reqack = 1'b1;
    expect_now("st_reqcyc_c3", S_REQCYC, 1);
    cyc();
    dc_if.reqack = 1'b0;
    expect_now("st_reqcyc_fall", S_REQCYC, 0);
    expect_now("st_stall_wait", S_STALL, 1);
    expect_now("st_respack_wait", S_RESPACK, 0);
    cyc();
    expect_now("st_no_retire_wait", S_RETIRE, 0);
    cyc();
    dc_if.respcyc = 1'b1;
    cyc();
    dc_if.respcyc = 1'b0;
    expect_now("st_respack", S_RESPACK, 1);
    expect_now("st_retire", S_RETIRE, 1);
    expect_now("st_stall_commit", S_STALL, 0);
    cyc();
    expect_now("st_respack_drop", S_RESPACK, 0);
    expect_now("st_retire_drop", S_RETIRE, 0);

    // Store with GPR write; ack and response together
    cyc();
    drive(1'b1, 64'h2000, 32'd6, 8'h42, 4'd6, 1'b1, 64'hCAFE, 4'd0, 1'b0, 64'h4008);
    push_store(64'h4008, 64'hCAFE, 13'h1142);
    push_retire(1'b1, 4'd6, 1'b0, 4'd0, 64'hCAFE, 64'h2006);
    cyc();
    validIn = 1'b0;
    expect_now("ar_reqcyc", S_REQCYC, 1);
    dc_if.reqack = 1'b1;
    dc_if.respcyc = 1'b1;
    cyc();
    dc_if.reqack = 1'b0;
    dc_if.respcyc = 1'b0;
    expect_now("ar_reqcyc_fall", S_REQCYC, 0);
    expect_now("ar_respack", S_RESPACK, 1);
    expect_now("ar_retire", S_RETIRE, 1);
    expect_now("ar_regWrEn", S_REGWR, 1);
    cyc();
    expect_now("ar_respack_drop", S_RESPACK, 0);
    expect_now("ar_no_reissue", S_REQCYC, 0);

    // validIn without isMemorySuccessfulIn is not accepted
    cyc();
    drive(1'b0, 64'h3000, 32'd1, 8'h00, 4'd1, 1'b1, 64'h1, 4'd0, 1'b0, 64'h0);
    isMemorySuccessfulIn = 1'b0;
    cyc();
    validIn = 1'b0;
    expect_now("nosucc_retire", S_RETIRE, 0);
    expect_now("nosucc_stall", S_STALL, 0);

    // Four back-to-back non-stores, including RIP wrap-around
    for (int i = 0; i < 4; i++) begin
      cyc();
      drive(1'b0, bb_rip[i], bb_len[i], 8'h10, bb_dst[i], 1'b1, bb_val[i], 4'd0, 1'b0, 64'h0);
      push_retire(1'b1, bb_dst[i], 1'b0, 4'd0, bb_val[i], bb_exp[i]);
      if (i > 0) expect_now("bb_retire", S_RETIRE, 1);
      expect_now("bb_stall", S_STALL, 0);
    end
    cyc();
    validIn = 1'b0;
    expect_now("bb_retire_last", S_RETIRE, 1);
    cyc();
    expect_now("bb_retire_drop", S_RETIRE, 0);

    // Reset during STORE_WAIT abandons the store
    cyc();
    drive(1'b1, 64'h5000, 32'd3, 8'h01, 4'd2, 1'b1, 64'h77, 4'd0, 1'b0, 64'h3000);
    push_store(64'h3000, 64'h77, 13'h1101);
    cyc();
    validIn = 1'b0;
    expect_now("rw_reqcyc", S_REQCYC, 1);
    dc_if.reqack = 1'b1;
    cyc();
    dc_if.reqack = 1'b0;
    expect_now("rw_reqcyc_fall", S_REQCYC, 0);
    expect_now("rw_stall_wait", S_STALL, 1);
    cyc();
    reset = 1'b0;
    cyc();
    reset = 1'b1;
    expect_now("rw_reqcyc_rst", S_REQCYC, 0);
    expect_now("rw_respack_rst", S_RESPACK, 0);
    expect_now("rw_regWrEn_rst", S_REGWR, 0);
    expect_now("rw_retire_rst", S_RETIRE, 0);
    expect_now("rw_stall_rst", S_STALL, 0);
    cyc();
    dc_if.respcyc = 1'b1;
    cyc();
    dc_if.respcyc = 1'b0;
    expect_now("rw_late_respack", S_RESPACK, 0);
    expect_now("rw_late_retire", S_RETIRE, 0);
    expect_now("rw_late_regWrEn", S_REGWR, 0);
    cyc();
    expect_now("rw_late_retire2", S_RETIRE, 0);

    cyc();
    expect_now("retires_outstanding", S_RQ_LEFT, 0);
    expect_now("stores_outstanding", S_SQ_LEFT, 0);
    cyc();
    cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/writeback_store.md
Name: writeback_store

Overview:
- Final pipeline stage, directly downstream of the memory-read stage.
- Takes each completed instruction from that stage and performs any memory-destination store through the data-cache core port using a req/ack/resp/respack handshake.
- Commits the GPR and special-register results with single-cycle write pulses, and publishes the retired next-RIP.
- Back-pressures the memory stage through wbStallOut while a store is in flight.

Parameters:
- ADDR_W, 64, store address width
- DATA_W, 64, store data and register write data width
- TAG_W, 13, request tag width: {op[0], type[3:0], opcode[7:0]}
- WRITE_CODE, 1'b1, op field value for a write request
- MEMORY_CODE, 4'h1, type field value for a data-memory request

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous active-low reset (asserted when 0)
- validIn  in  1  opcodeValid from the memory stage
- isMemorySuccessfulIn  in  1  memory stage finished its read, or had none
- currentRipIn  in  64  RIP of the instruction
- instructionLengthIn  in  32  byte length of the instruction
- opcodeIn  in  8  opcode, copied into the request tag
- destRegIn  in  4  GPR destination index
- destRegValidIn  in  1  GPR write required
- destRegValueIn  in  64  result value; this is also the store data
- destRegSpecialIn  in  4  special-register index
- destRegSpecialValidIn  in  1  special-register write required
- isMemoryAccessDestIn  in  1  destination is memory
- memoryAddressDestIn  in  ADDR_W  store address
- wbStallOut  out  1  memory stage must hold its outputs
- reqcyc  out  1  store request valid
- req  out  ADDR_W  store address
- reqdata  out  DATA_W  store data
- reqtag  out  TAG_W  {WRITE_CODE, MEMORY_CODE, opcode}
- reqack  in  1  cache accepted the request
- respcyc  in  1  store completion
- respack  out  1  completion acknowledge, one-cycle pulse
- regWrEn  out  1  GPR write strobe
- regWrIdx  out  4  GPR index
- regWrData  out  DATA_W  GPR data
- specWrEn  out  1  special-register write strobe
- specWrIdx  out  4  special-register index
- specWrData  out  DATA_W  special-register data
- retireValidOut  out  1  instruction retired this cycle
- retiredRipOut  out  64  currentRip + instructionLength

Behaviour:
- States: IDLE, STORE_REQ, STORE_WAIT, COMMIT. All outputs except wbStallOut are registered.
- Reset (reset==0 at a clk edge) forces IDLE and sets every registered output to 0.
  - This holds mid-store as well: the request is abandoned, and no reg write or retire occurs.
- ready = (state==IDLE || state==COMMIT).
  - wbStallOut = !ready, combinational.
  - accept = validIn && isMemorySuccessfulIn && ready.
- On accept, latch all instruction fields, then:
  - non-store: next state COMMIT.
  - store: next state STORE_REQ, with reqcyc<=1, req<=addr, reqdata<=destRegValueIn, reqtag<=tag.
- Non-store instruction: write strobes appear the cycle after accept, so latency is 1 cycle.
- STORE_REQ:
  - req, reqdata and reqtag are held stable while reqcyc==1.
  - reqack==1 → reqcyc<=0 and go to STORE_WAIT.
  - If respcyc==1 in the same cycle as reqack: go straight to COMMIT, respack<=1.
  - respcyc without reqack is ignored.
- STORE_WAIT: respcyc==1 → respack<=1 (exactly one cycle), go to COMMIT. Otherwise wait indefinitely; there is no timeout.
- COMMIT (exactly one cycle):
  - regWrEn=destRegValid, specWrEn=destRegSpecialValid.
  - regWrData and specWrData both carry the latched destRegValue.
  - retireValidOut=1; retiredRipOut = latched RIP + zero-extended length, modulo 2^64.
  - Strobes drop the following cycle unless a new COMMIT follows.
- COMMIT with accept in the same cycle: the next state is taken from the new instruction. This sustains back-to-back non-store retirement at 1 per cycle.
- A store with destRegValid=1 performs both the store and the GPR write, the GPR write occurring in COMMIT.
- validIn without isMemorySuccessfulIn: no accept; state is unchanged.

Test Plan:
- Reset, then a non-store: dest=3, value=0xDEAD, RIP=0x1000, len=3 → one cycle later: regWrEn=1, regWrIdx=3, regWrData=0xDEAD, retiredRipOut=0x1003, wbStallOut=0 throughout.
- Store to 0x2000, data 0x55, opcode 0x89:
  - reqcyc rises the cycle after accept with reqtag={1,1,0x89}.
  - reqack at cycle+3 → reqcyc falls.
  - respcyc 2 cycles later → respack pulses once, then retire.
  - wbStallOut=1 from cycle+1 until COMMIT.
- reqack and respcyc in the same cycle during STORE_REQ → COMMIT next cycle, respack exactly one cycle, no further request issued.
- Four back-to-back non-stores → four consecutive retireValidOut pulses with no bubbles.
- reset=0 during STORE_WAIT → next cycle reqcyc=0, respack=0, no regWrEn, no retire; a later respcyc is ignored.
- RIP=0xFFFFFFFFFFFFFFFE, len=4 → retiredRipOut=0x2.
